// File: rtl/mem_bus_pkg.sv
// Shared state encoding, grant one-hot constants and default line size for mem_bus_arbiter.
package mem_bus_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      RESP = 2'b10
   } arb_state_t;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_IC   = 2'b01;
   localparam logic [1:0] GNT_DC   = 2'b10;

   localparam int DEFAULT_BEATS = 8;
endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way picker: a lone requester always wins, ties go to i_prefer_dc.
module arb_pick2
   import mem_bus_pkg::*;
(
   input  logic       i_req_ic,
   input  logic       i_req_dc,
   input  logic       i_prefer_dc,
   output logic [1:0] o_pick
);
   always_comb begin
      o_pick = GNT_NONE;
      if (i_req_ic && i_req_dc) begin
         o_pick = i_prefer_dc ? GNT_DC : GNT_IC;
      end else if (i_req_ic) begin
         o_pick = GNT_IC;
      end else if (i_req_dc) begin
         o_pick = GNT_DC;
      end
   end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the ic and dc requesters onto one shared bus, one line transaction at a time.
// Define ARB_ROUND_ROBIN_EN to break ties toward the requester not granted last.
//
// state | meaning
// IDLE  | no owner; pick a winner from pending reqcyc
// REQ   | owner's request driven on the bus until bus_reqack (or owner withdraws)
// RESP  | owner receives BEATS acknowledged response beats
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int BEATS          = DEFAULT_BEATS
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ic_bus_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] ic_bus_req,
   input  logic [BUS_TAG_WIDTH-1:0]  ic_bus_reqtag,
   input  logic                      ic_bus_respack,
   output logic                      ic_bus_reqack,
   output logic                      ic_bus_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] ic_bus_resp,
   output logic [BUS_TAG_WIDTH-1:0]  ic_bus_resptag,
   input  logic                      dc_bus_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] dc_bus_req,
   input  logic [BUS_TAG_WIDTH-1:0]  dc_bus_reqtag,
   input  logic                      dc_bus_respack,
   output logic                      dc_bus_reqack,
   output logic                      dc_bus_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] dc_bus_resp,
   output logic [BUS_TAG_WIDTH-1:0]  dc_bus_resptag,
   output logic                      bus_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_req,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   output logic                      bus_respack,
   input  logic                      bus_reqack,
   input  logic                      bus_respcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   output logic [1:0]                grant
);
   localparam int CW = $clog2(BEATS) + 1;

   arb_state_t     r_state, w_state_nxt;
   logic [1:0]     r_grant, w_grant_nxt, w_pick;
   logic [CW-1:0]  r_beat_cnt, w_beat_cnt_nxt, w_beat_cnt_inc;
   logic           w_own_ic, w_own_dc, w_own_reqcyc, w_own_respack, w_prefer_dc;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_prefer_dc;

   // Pointer remembers who won the last grant so the other side wins the next tie.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prefer_dc <= 1'b0;
      end else if (r_state == IDLE && w_pick != GNT_NONE) begin
         r_prefer_dc <= w_pick[0];
      end
   end
   assign w_prefer_dc = r_prefer_dc;
`else
   assign w_prefer_dc = 1'b0;
`endif

   arb_pick2 u_pick (
      .i_req_ic    (ic_bus_reqcyc),
      .i_req_dc    (dc_bus_reqcyc),
      .i_prefer_dc (w_prefer_dc),
      .o_pick      (w_pick)
   );

   assign w_own_ic       = r_grant[0];
   assign w_own_dc       = r_grant[1];
   assign w_own_reqcyc   = (w_own_ic & ic_bus_reqcyc) | (w_own_dc & dc_bus_reqcyc);
   assign w_own_respack  = (w_own_ic & ic_bus_respack) | (w_own_dc & dc_bus_respack);
   assign w_beat_cnt_inc = r_beat_cnt + 1'b1;
   assign grant          = r_grant;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_grant    <= GNT_NONE;
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant;
      w_beat_cnt_nxt = r_beat_cnt;
      case (r_state)
         IDLE: begin
            if (w_pick != GNT_NONE) begin
               w_state_nxt = REQ;
               w_grant_nxt = w_pick;
            end
         end
         REQ: begin
            if (!w_own_reqcyc) begin
               w_state_nxt = IDLE;
               w_grant_nxt = GNT_NONE;
            end else if (bus_reqack) begin
               w_state_nxt    = RESP;
               w_beat_cnt_nxt = '0;
            end
         end
         RESP: begin
            if (bus_respcyc && w_own_respack) begin
               w_beat_cnt_nxt = w_beat_cnt_inc;
               if (w_beat_cnt_inc == CW'(BEATS)) begin
                  w_state_nxt = IDLE;
                  w_grant_nxt = GNT_NONE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_grant_nxt = GNT_NONE;
         end
      endcase
   end

   // Everything is derived from registered state, so async reset zeroes the outputs at once.
   always_comb begin
      bus_reqcyc     = 1'b0;
      bus_req        = '0;
      bus_reqtag     = '0;
      bus_respack    = 1'b0;
      ic_bus_reqack  = 1'b0;
      dc_bus_reqack  = 1'b0;
      ic_bus_respcyc = 1'b0;
      dc_bus_respcyc = 1'b0;
      ic_bus_resp    = '0;
      dc_bus_resp    = '0;
      ic_bus_resptag = '0;
      dc_bus_resptag = '0;
      case (r_state)
         REQ: begin
            bus_reqcyc    = w_own_reqcyc;
            bus_req       = w_own_dc ? dc_bus_req    : ic_bus_req;
            bus_reqtag    = w_own_dc ? dc_bus_reqtag : ic_bus_reqtag;
            ic_bus_reqack = w_own_ic & bus_reqack;
            dc_bus_reqack = w_own_dc & bus_reqack;
         end
         RESP: begin
            bus_respack    = w_own_respack;
            ic_bus_respcyc = w_own_ic & bus_respcyc;
            dc_bus_respcyc = w_own_dc & bus_respcyc;
            if (w_own_ic) begin
               ic_bus_resp    = bus_resp;
               ic_bus_resptag = bus_resptag;
            end
            if (w_own_dc) begin
               dc_bus_resp    = bus_resp;
               dc_bus_resptag = bus_resptag;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: arbitration vector table plus hand-written transaction sequences.
module tb_mem_bus_arbiter;
   import mem_bus_pkg::*;

   localparam int DW = 64;
   localparam int TW = 13;
   localparam int NB = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          ic_bus_reqcyc, ic_bus_respack, ic_bus_reqack, ic_bus_respcyc;
   logic [DW-1:0] ic_bus_req, ic_bus_resp;
   logic [TW-1:0] ic_bus_reqtag, ic_bus_resptag;
   logic          dc_bus_reqcyc, dc_bus_respack, dc_bus_reqack, dc_bus_respcyc;
   logic [DW-1:0] dc_bus_req, dc_bus_resp;
   logic [TW-1:0] dc_bus_reqtag, dc_bus_resptag;
   logic          bus_reqcyc, bus_respack, bus_reqack, bus_respcyc;
   logic [DW-1:0] bus_req, bus_resp;
   logic [TW-1:0] bus_reqtag, bus_resptag;
   logic [1:0]    grant;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(NB)) dut (
      .clk(clk), .reset(reset),
      .ic_bus_reqcyc(ic_bus_reqcyc), .ic_bus_req(ic_bus_req), .ic_bus_reqtag(ic_bus_reqtag),
      .ic_bus_respack(ic_bus_respack), .ic_bus_reqack(ic_bus_reqack), .ic_bus_respcyc(ic_bus_respcyc),
      .ic_bus_resp(ic_bus_resp), .ic_bus_resptag(ic_bus_resptag),
      .dc_bus_reqcyc(dc_bus_reqcyc), .dc_bus_req(dc_bus_req), .dc_bus_reqtag(dc_bus_reqtag),
      .dc_bus_respack(dc_bus_respack), .dc_bus_reqack(dc_bus_reqack), .dc_bus_respcyc(dc_bus_respcyc),
      .dc_bus_resp(dc_bus_resp), .dc_bus_resptag(dc_bus_resptag),
      .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_respack(bus_respack),
      .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
      .grant(grant)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic [TW-1:0] tag;
   } beat_t;

   typedef struct {
      logic       ic;
      logic       dc;
      logic [1:0] g;
   } vec_t;

   beat_t sb[$];
   vec_t  vecs[5];
   int    total = 0;
   int    bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      ic_bus_reqcyc = 1'b0; dc_bus_reqcyc = 1'b0;
      ic_bus_respack = 1'b0; dc_bus_respack = 1'b0;
      bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   // From IDLE: raise requests, expect no grant this cycle and exp_g after one edge.
   task automatic arb_start(input logic ic_r, input logic dc_r, input logic [1:0] exp_g);
      ic_bus_reqcyc = ic_r;
      dc_bus_reqcyc = dc_r;
      #1;
      chk("idle_grant", 64'(grant), 64'(GNT_NONE));
      chk("idle_bus_reqcyc", 64'(bus_reqcyc), 64'd0);
      step();
      chk("start_grant", 64'(grant), 64'(exp_g));
      chk("start_bus_reqcyc", 64'(bus_reqcyc), 64'd1);
      chk("start_bus_req", bus_req, (exp_g == GNT_DC) ? dc_bus_req : ic_bus_req);
      chk("start_bus_reqtag", 64'(bus_reqtag), 64'((exp_g == GNT_DC) ? dc_bus_reqtag : ic_bus_reqtag));
   endtask

   task automatic reqack(input bit dc, input int wait_cyc);
      repeat (wait_cyc) begin
         chk("wait_reqack", 64'(dc ? dc_bus_reqack : ic_bus_reqack), 64'd0);
         step();
      end
      bus_reqack = 1'b1;
      #1;
      chk("owner_reqack", 64'(dc ? dc_bus_reqack : ic_bus_reqack), 64'd1);
      chk("other_reqack", 64'(dc ? ic_bus_reqack : dc_bus_reqack), 64'd0);
      step();
      bus_reqack = 1'b0;
      if (dc) dc_bus_reqcyc = 1'b0;
      else    ic_bus_reqcyc = 1'b0;
      chk("resp_bus_reqcyc", 64'(bus_reqcyc), 64'd0);
   endtask

   // Drive response beats until n are acknowledged; cycle nack_at carries respack=0.
   task automatic beats(input bit dc, input int n, input int nack_at, input bit fin);
      int    acked = 0;
      int    cyc = 0;
      bit    ack;
      beat_t b, e;
      while (acked < n && cyc < 40) begin
         ack    = (cyc != nack_at);
         b.data = {$urandom, $urandom};
         b.tag  = TW'($urandom);
         bus_respcyc = 1'b1; bus_resp = b.data; bus_resptag = b.tag;
         ic_bus_respack = !dc && ack;
         dc_bus_respack = dc && ack;
         sb.push_back(b);
         #1;
         e = sb.pop_front();
         chk("beat_grant", 64'(grant), 64'(dc ? GNT_DC : GNT_IC));
         chk("beat_owner_resp", dc ? dc_bus_resp : ic_bus_resp, e.data);
         chk("beat_owner_tag", 64'(dc ? dc_bus_resptag : ic_bus_resptag), 64'(e.tag));
         chk("beat_owner_respcyc", 64'(dc ? dc_bus_respcyc : ic_bus_respcyc), 64'd1);
         chk("beat_other_respcyc", 64'(dc ? ic_bus_respcyc : dc_bus_respcyc), 64'd0);
         chk("beat_other_resp", dc ? ic_bus_resp : dc_bus_resp, 64'd0);
         chk("beat_respack", 64'(bus_respack), 64'(ack));
         step();
         if (ack) acked++;
         cyc++;
      end
      bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
      ic_bus_respack = 1'b0; dc_bus_respack = 1'b0;
      if (acked < n) chk("beat_budget", 64'(acked), 64'(n));
      if (fin) chk("done_grant", 64'(grant), 64'(GNT_NONE));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      logic [1:0] second;
      vecs[0] = '{ic: 1'b0, dc: 1'b0, g: GNT_NONE};
      vecs[1] = '{ic: 1'b1, dc: 1'b0, g: GNT_IC};
      vecs[2] = '{ic: 1'b0, dc: 1'b1, g: GNT_DC};
      vecs[3] = '{ic: 1'b1, dc: 1'b1, g: GNT_IC};
`ifdef ARB_ROUND_ROBIN_EN
      vecs[4] = '{ic: 1'b1, dc: 1'b1, g: GNT_DC};
      second  = GNT_DC;
`else
      vecs[4] = '{ic: 1'b1, dc: 1'b1, g: GNT_IC};
      second  = GNT_IC;
`endif
      ic_bus_req = 64'h1C1C_0000_AAAA_5555; ic_bus_reqtag = 13'h0A1;
      dc_bus_req = 64'hDCDC_1111_3333_CCCC; dc_bus_reqtag = 13'h1D2;
      clear_inputs();
      reset = 1'b0;
      ic_bus_reqcyc = 1'b1;
      bus_respcyc = 1'b1;
      @(negedge clk);
      chk("rst_grant", 64'(grant), 64'(GNT_NONE));
      chk("rst_bus_reqcyc", 64'(bus_reqcyc), 64'd0);
      chk("rst_ic_respcyc", 64'(ic_bus_respcyc), 64'd0);
      clear_inputs();
      reset = 1'b1;

      // arbitration table; every grant is withdrawn before reqack
      for (int i = 0; i < 5; i++) begin
         ic_bus_reqcyc = vecs[i].ic;
         dc_bus_reqcyc = vecs[i].dc;
         #1;
         chk($sformatf("vec%0d_pre_grant", i), 64'(grant), 64'(GNT_NONE));
         step();
         chk($sformatf("vec%0d_grant", i), 64'(grant), 64'(vecs[i].g));
         chk($sformatf("vec%0d_bus_reqcyc", i), 64'(bus_reqcyc), 64'(vecs[i].g != GNT_NONE));
         chk($sformatf("vec%0d_bus_reqtag", i), 64'(bus_reqtag),
             64'((vecs[i].g == GNT_IC) ? ic_bus_reqtag : (vecs[i].g == GNT_DC) ? dc_bus_reqtag : 13'd0));
         ic_bus_reqcyc = 1'b0;
         dc_bus_reqcyc = 1'b0;
         step();
         chk($sformatf("vec%0d_drop_grant", i), 64'(grant), 64'(GNT_NONE));
         chk($sformatf("vec%0d_drop_reqcyc", i), 64'(bus_reqcyc), 64'd0);
      end

      // single ic line, reqack in the third REQ cycle
      arb_start(1'b1, 1'b0, GNT_IC);
      reqack(1'b0, 2);
      beats(1'b0, NB, -1, 1'b1);

      // back-to-back ties from a fresh pointer
      do_reset();
      arb_start(1'b1, 1'b1, GNT_IC);
      reqack(1'b0, 0);
      beats(1'b0, NB, -1, 1'b1);
      arb_start(1'b1, 1'b1, second);
      reqack(second == GNT_DC, 0);
      beats(second == GNT_DC, NB, -1, 1'b1);
      clear_inputs();
      step();

      // owner withdraws before reqack, dc takes over, then dc respack pattern 1,0,1,...
      arb_start(1'b1, 1'b0, GNT_IC);
      ic_bus_reqcyc = 1'b0;
      dc_bus_reqcyc = 1'b1;
      #1;
      chk("withdraw_bus_reqcyc", 64'(bus_reqcyc), 64'd0);
      step();
      chk("withdraw_grant", 64'(grant), 64'(GNT_NONE));
      chk("withdraw_idle_reqcyc", 64'(bus_reqcyc), 64'd0);
      step();
      chk("other_granted", 64'(grant), 64'(GNT_DC));
      reqack(1'b1, 1);
      beats(1'b1, NB, 1, 1'b1);

      // reset in the middle of a response
      arb_start(1'b1, 1'b0, GNT_IC);
      reqack(1'b0, 0);
      beats(1'b0, 4, -1, 1'b0);
      chk("mid_grant", 64'(grant), 64'(GNT_IC));
      bus_respcyc = 1'b1; bus_resp = 64'hFEED_F00D_0000_0001; bus_resptag = 13'h055;
      ic_bus_respack = 1'b1;
      reset = 1'b0;
      #1;
      chk("mid_rst_grant", 64'(grant), 64'(GNT_NONE));
      chk("mid_rst_ic_respcyc", 64'(ic_bus_respcyc), 64'd0);
      chk("mid_rst_ic_resp", ic_bus_resp, 64'd0);
      chk("mid_rst_ic_resptag", 64'(ic_bus_resptag), 64'd0);
      chk("mid_rst_bus_respack", 64'(bus_respack), 64'd0);
      step();
      clear_inputs();
      reset = 1'b1;
      step();
      arb_start(1'b1, 1'b0, GNT_IC);
      ic_bus_reqcyc = 1'b0;
      step();
      chk("final_idle", 64'(grant), 64'(GNT_NONE));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
